median_filter_n: RTL and testbench

MEDIAN_FILTER_N -- requirements
Module: median_filter_n

---
 rtl/median_filter_n.sv | 119 +++++++++++
 tb/tb_median_filter_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/median_filter_n.sv
// Streaming running-median filter over the last DEPTH accepted samples.
// Three-stage pipeline: input register, window/sorted-array update, output register.
module median_filter_n #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic             start,
  input  logic             clear,
  output logic [WIDTH-1:0] y,
  output logic             eoc,
  output logic             primed
);

  localparam int MID = (DEPTH - 1) / 2;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_x;
  logic             s2_warm;

  logic [WIDTH-1:0] hist        [DEPTH];
  logic [WIDTH-1:0] sorted      [DEPTH];
  logic [WIDTH-1:0] next_sorted [DEPTH];
  logic [CW-1:0]    fill;
  logic [PW-1:0]    ptr;
  logic             full;
  logic             warm;

  // Remove the oldest value (first match) once full, then insert the new sample in order.
  always_comb begin
    logic [WIDTH-1:0] oldest;
    logic [WIDTH-1:0] pruned [DEPTH];
    int               rm;
    int               n;
    int               pos;
    logic             found;

    full   = (fill == CW'(DEPTH));
    warm   = (int'(fill) < DEPTH - 1);
    oldest = hist[ptr];
    rm     = DEPTH - 1;
    found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && sorted[i] == oldest) begin
        rm    = i;
        found = 1'b1;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (full && i >= rm && i < DEPTH - 1) pruned[i] = sorted[i+1];
      else                                  pruned[i] = sorted[i];
    end

    n   = full ? DEPTH - 1 : int'(fill);
    pos = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < n && pruned[i] < s1_x) pos++;
    end

    next_sorted[0] = (pos == 0) ? s1_x : pruned[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (i < pos)       next_sorted[i] = pruned[i];
      else if (i == pos) next_sorted[i] = s1_x;
      else               next_sorted[i] = pruned[i-1];
    end
  end

  // Control state; clear cancels everything in flight but lets a same-cycle start through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      fill     <= '0;
      ptr      <= '0;
      y        <= '0;
      eoc      <= 1'b0;
      primed   <= 1'b0;
    end else begin
      s1_valid <= start;
      if (clear) begin
        s2_valid <= 1'b0;
        fill     <= '0;
        ptr      <= '0;
        eoc      <= 1'b0;
        primed   <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        eoc      <= s2_valid;
        if (s1_valid) begin
          fill <= full ? fill : fill + CW'(1);
          ptr  <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
        if (s2_valid) begin
          y      <= s2_warm ? s2_x : sorted[MID];
          primed <= !s2_warm;
        end
      end
    end
  end

  // Datapath storage needs no reset; validity is tracked by the control flops above.
  always_ff @(posedge clk) begin
    s1_x    <= x;
    s2_x    <= s1_x;
    s2_warm <= warm;
    if (s1_valid && !clear) begin
      hist[ptr] <= s1_x;
      sorted    <= next_sorted;
    end
  end

endmodule

// File: tb/tb_median_filter_n.sv
// Randomised bench for median_filter_n at DEPTH 5, 3 and 15 against a sliding-window
// reference that keeps the raw sample queue and sorts a copy for every median.
module tb_median_filter_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y [3];
  logic       eoc [3];
  logic       primed [3];

  int  dep [3] = '{5, 3, 15};
  int  win [3][$];
  bit  slot_valid [3][4];
  int  slot_y [3][4];
  bit  slot_primed [3][4];
  int  exp_y [3];
  bit  exp_eoc [3];
  bit  exp_primed [3];
  int  cycle = 0;
  int  checks = 0;
  int  failures = 0;
  int  start_count = 0;
  int  eoc_count = 0;

  always #5 clk = ~clk;

  median_filter_n #(.WIDTH(10), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .x(x), .start(start), .clear(clear),
    .y(y[0]), .eoc(eoc[0]), .primed(primed[0]));
  median_filter_n #(.WIDTH(10), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x(x), .start(start), .clear(clear),
    .y(y[1]), .eoc(eoc[1]), .primed(primed[1]));
  median_filter_n #(.WIDTH(10), .DEPTH(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .x(x), .start(start), .clear(clear),
    .y(y[2]), .eoc(eoc[2]), .primed(primed[2]));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int medianOf(input int k);
    int srt[$];
    srt = win[k];
    srt.sort();
    return srt[(dep[k] - 1) / 2];
  endfunction

  task automatic flushModel();
    for (int k = 0; k < 3; k++) begin
      win[k].delete();
      for (int s = 0; s < 4; s++) slot_valid[k][s] = 1'b0;
      exp_eoc[k]    = 1'b0;
      exp_primed[k] = 1'b0;
    end
  endtask

  // One clock edge as the reference sees it: emit what is due, then accept the new sample.
  task automatic modelEdge(input bit s, input int xv, input bit c);
    int due;
    cycle++;
    due = cycle % 4;
    if (c) flushModel();
    for (int k = 0; k < 3; k++) begin
      if (!c) begin
        exp_eoc[k] = slot_valid[k][due];
        if (slot_valid[k][due]) begin
          exp_y[k]      = slot_y[k][due];
          exp_primed[k] = slot_primed[k][due];
        end
        slot_valid[k][due] = 1'b0;
      end
      if (s) begin
        win[k].push_back(xv);
        if (win[k].size() > dep[k]) void'(win[k].pop_front());
        slot_valid[k][(cycle + 2) % 4]  = 1'b1;
        slot_primed[k][(cycle + 2) % 4] = (win[k].size() == dep[k]);
        slot_y[k][(cycle + 2) % 4]      = (win[k].size() == dep[k]) ? medianOf(k) : xv;
      end
    end
  endtask

  task automatic compareAll();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("eoc_d%0d", dep[k]), int'(eoc[k]), int'(exp_eoc[k]));
      checkOutput($sformatf("y_d%0d", dep[k]), int'(y[k]), exp_y[k]);
      checkOutput($sformatf("primed_d%0d", dep[k]), int'(primed[k]), int'(exp_primed[k]));
    end
    if (eoc[0]) eoc_count++;
  endtask

  task automatic applyStimulus(input bit s, input int xv, input bit c);
    start = s;
    x     = xv[9:0];
    clear = c;
    @(posedge clk);
    modelEdge(s, xv, c);
    @(negedge clk);
    compareAll();
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
  endtask

  // Called just after a falling edge; the low pulse ends before the next rising edge.
  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_y_d%0d", dep[k]), int'(y[k]), 0);
      checkOutput($sformatf("rst_eoc_d%0d", dep[k]), int'(eoc[k]), 0);
      checkOutput($sformatf("rst_primed_d%0d", dep[k]), int'(primed[k]), 0);
      exp_y[k] = 0;
    end
    flushModel();
    #1 rst_n = 1'b1;
  endtask

  function automatic int randSample();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) exp_y[k] = 0;
    flushModel();
    @(negedge clk);
    compareAll();
    rst_n = 1'b1;

    foreach (dep[k]) ;
    applyStimulus(1'b1, 10, 1'b0);
    applyStimulus(1'b1, 50, 1'b0);
    applyStimulus(1'b1, 20, 1'b0);
    applyStimulus(1'b1, 40, 1'b0);
    applyStimulus(1'b1, 30, 1'b0);
    applyStimulus(1'b1, 1000, 1'b0);
    idle(2);
    checkOutput("slide_y", int'(y[0]), 40);
    checkOutput("slide_primed", int'(primed[0]), 1);

    applyStimulus(1'b0, 0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 100, 1'b0);
    applyStimulus(1'b1, 1023, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 100, 1'b0);
    idle(2);
    checkOutput("impulse_y", int'(y[2]), 100);

    eoc_count   = 0;
    start_count = 0;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'b1, randSample(), 1'b0);
      start_count++;
      idle($urandom_range(0, 3));
    end
    idle(3);
    checkOutput("eoc_count", eoc_count, start_count);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, randSample(), 1'b0);
    applyStimulus(1'b1, 7, 1'b1);
    idle(2);
    checkOutput("clr_start_y", int'(y[0]), 7);
    checkOutput("clr_start_primed", int'(primed[0]), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, randSample(), 1'b0);
    applyStimulus(1'b1, 123, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    idle(3);
    applyStimulus(1'b1, 321, 1'b0);
    idle(1);
    applyStimulus(1'b0, 0, 1'b1);
    idle(3);

    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 55, 1'b0);
    applyStimulus(1'b1, 55, 1'b0);
    applyStimulus(1'b1, 55, 1'b0);
    pulseReset();
    idle(4);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, randSample(), 1'b0);
    applyStimulus(1'b1, 9, 1'b0);
    pulseReset();
    idle(3);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randSample(), 1'($urandom_range(0, 39) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
